irrigation_scheduler: RTL and testbench

//  Sequences one irrigation valve from a minute time base supplied by the timer block.

---
 rtl/irrigation_scheduler.sv | 129 ++++++++++++
 tb/tb_irrigation_scheduler.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/irrigation_scheduler.sv
// Single-valve irrigation sequencer driven by a minute tick: dose, rest and
// low-reservoir lockout. Every output comes from a flop.
module irrigation_scheduler #(
    parameter int unsigned WATER_MIN = 5,
    parameter int unsigned REST_MIN  = 10,
    parameter int unsigned CNT_W     = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tick_min,
    input  logic             soil_dry,
    input  logic             water_low,
    input  logic             start_manual,
    input  logic             abort,
    output logic             valve,
    output logic             alarm,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] minutes_left,
    output logic             timer_clear,
    output logic [7:0]       dose_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        WATERING = 2'b01,
        REST     = 2'b10,
        FAULT    = 2'b11
    } state_e;

    localparam logic [CNT_W-1:0] WATER_LOAD = CNT_W'(WATER_MIN);
    localparam logic [CNT_W-1:0] REST_LOAD  = CNT_W'(REST_MIN);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] minutes_q, minutes_d;
    logic [7:0]       dose_q, dose_d;
    logic             tclr_q, tclr_d;
    logic             valve_q, valve_d;
    logic             alarm_q, alarm_d;

    always_comb begin
        state_d   = state_q;
        minutes_d = minutes_q;
        dose_d    = dose_q;
        tclr_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                minutes_d = '0;
                if (water_low) begin
                    state_d = FAULT;
                end else if (soil_dry || start_manual) begin
                    state_d   = WATERING;
                    minutes_d = WATER_LOAD;
                    tclr_d    = 1'b1;
                end
            end
            WATERING: begin
                if (water_low) begin
                    state_d   = FAULT;
                    minutes_d = '0;
                end else if (abort) begin
                    state_d   = REST;
                    minutes_d = REST_LOAD;
                    tclr_d    = 1'b1;
                end else if (tick_min) begin
                    // A count of 1 (or a defensive 0) ends the dose instead of underflowing.
                    if (minutes_q > CNT_W'(1)) begin
                        minutes_d = minutes_q - CNT_W'(1);
                    end else begin
                        state_d   = REST;
                        minutes_d = REST_LOAD;
                        dose_d    = dose_q + 8'd1;
                        tclr_d    = 1'b1;
                    end
                end
            end
            REST: begin
                if (water_low) begin
                    state_d   = FAULT;
                    minutes_d = '0;
                end else if (tick_min) begin
                    if (minutes_q > CNT_W'(1)) begin
                        minutes_d = minutes_q - CNT_W'(1);
                    end else begin
                        state_d   = IDLE;
                        minutes_d = '0;
                    end
                end
            end
            FAULT: begin
                minutes_d = '0;
                if (tick_min && !water_low) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                minutes_d = '0;
            end
        endcase
        valve_d = (state_d == WATERING);
        alarm_d = (state_d == FAULT);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            minutes_q <= '0;
            dose_q    <= '0;
            tclr_q    <= 1'b0;
            valve_q   <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            minutes_q <= minutes_d;
            dose_q    <= dose_d;
            tclr_q    <= tclr_d;
            valve_q   <= valve_d;
            alarm_q   <= alarm_d;
        end
    end

    assign state        = state_q;
    assign minutes_left = minutes_q;
    assign dose_count   = dose_q;
    assign timer_clear  = tclr_q;
    assign valve        = valve_q;
    assign alarm        = alarm_q;

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Directed bench for irrigation_scheduler: expectations are queued with each
// stimulus step and checked one cycle later against the registered outputs.
module tb_irrigation_scheduler;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_WAT  = 2'b01;
    localparam logic [1:0] S_REST = 2'b10;
    localparam logic [1:0] S_FLT  = 2'b11;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset, tick_min, soil_dry, water_low, start_manual, abort;

    logic       valve_a, alarm_a, tclr_a;
    logic [1:0] state_a;
    logic [5:0] min_a;
    logic [7:0] dose_a;

    logic       valve_b, alarm_b, tclr_b;
    logic [1:0] state_b;
    logic [5:0] min_b;
    logic [7:0] dose_b;

    irrigation_scheduler #(.WATER_MIN(5), .REST_MIN(10), .CNT_W(6)) dut_a (
        .clock(clock), .reset(reset), .tick_min(tick_min), .soil_dry(soil_dry),
        .water_low(water_low), .start_manual(start_manual), .abort(abort),
        .valve(valve_a), .alarm(alarm_a), .state(state_a), .minutes_left(min_a),
        .timer_clear(tclr_a), .dose_count(dose_a)
    );

    irrigation_scheduler #(.WATER_MIN(1), .REST_MIN(1), .CNT_W(6)) dut_b (
        .clock(clock), .reset(reset), .tick_min(tick_min), .soil_dry(soil_dry),
        .water_low(water_low), .start_manual(start_manual), .abort(abort),
        .valve(valve_b), .alarm(alarm_b), .state(state_b), .minutes_left(min_b),
        .timer_clear(tclr_b), .dose_count(dose_b)
    );

    typedef struct {
        string      tag;
        bit         sel;
        logic [1:0] st;
        logic       v;
        logic       al;
        logic [5:0] m;
        logic       tc;
        logic [7:0] d;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    task automatic push(input string tag, input bit sel, input logic [1:0] st, input logic v,
                        input logic al, input logic [5:0] m, input logic tc, input logic [7:0] d);
        exp_t e;
        e.tag = tag; e.sel = sel; e.st = st; e.v = v; e.al = al; e.m = m; e.tc = tc; e.d = d;
        sb.push_back(e);
    endtask

    task automatic check_all();
        while (sb.size() > 0) begin
            exp_t        e;
            logic [18:0] obs, expv;
            e    = sb.pop_front();
            obs  = e.sel ? {state_b, valve_b, alarm_b, min_b, tclr_b, dose_b}
                         : {state_a, valve_a, alarm_a, min_a, tclr_a, dose_a};
            expv = {e.st, e.v, e.al, e.m, e.tc, e.d};
            compared++;
            assert (obs === expv) else begin
                mismatched++;
                $error("FAIL %s: observed st=%0d valve=%0b alarm=%0b min=%0d tclr=%0b dose=%0d, required st=%0d valve=%0b alarm=%0b min=%0d tclr=%0b dose=%0d",
                       e.tag, obs[18:17], obs[16], obs[15], obs[14:9], obs[8], obs[7:0],
                       e.st, e.v, e.al, e.m, e.tc, e.d);
            end
        end
    endtask

    // Drive one cycle of inputs, clock it, then check whatever was queued.
    task automatic step(input logic r, input logic tk, input logic sd, input logic wl,
                        input logic sm, input logic ab);
        @(negedge clock);
        reset = r; tick_min = tk; soil_dry = sd; water_low = wl; start_manual = sm; abort = ab;
        @(posedge clock);
        #1;
        check_all();
    endtask

    initial begin
        reset = 1'b0; tick_min = 1'b0; soil_dry = 1'b0;
        water_low = 1'b0; start_manual = 1'b0; abort = 1'b0;

        step(0, 0, 0, 0, 0, 0);
        push("reset", 0, S_IDLE, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 1, 0);

        push("dry_start", 0, S_WAT, 1, 0, 5, 1, 0);
        step(1, 0, 1, 0, 0, 0);
        push("tclr_one_cycle", 0, S_WAT, 1, 0, 5, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            push("water_tick", 0, S_WAT, 1, 0, 6'(5 - i), 0, 0);
            step(1, 1, 0, 0, 0, 0);
        end
        push("dose_done", 0, S_REST, 0, 0, 10, 1, 1);
        step(1, 1, 0, 0, 0, 0);

        for (int i = 1; i <= 9; i++) begin
            push("rest_tick", 0, S_REST, 0, 0, 6'(10 - i), 0, 1);
            step(1, 1, 1, 0, (i == 3), 0);
        end
        push("rest_done", 0, S_IDLE, 0, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0, 0);

        push("manual_start", 0, S_WAT, 1, 0, 5, 1, 1);
        step(1, 0, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0);
        push("abort_pre", 0, S_WAT, 1, 0, 3, 0, 1);
        step(1, 1, 0, 0, 0, 0);
        push("abort", 0, S_REST, 0, 0, 10, 1, 1);
        step(1, 0, 0, 0, 0, 1);
        for (int i = 1; i <= 9; i++) step(1, 1, 0, 0, 0, 0);
        push("abort_rest_done", 0, S_IDLE, 0, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0, 0);

        push("start_tick_prio", 0, S_WAT, 1, 0, 5, 1, 1);
        step(1, 1, 0, 0, 1, 0);
        for (int i = 1; i <= 3; i++) step(1, 1, 0, 0, 0, 0);
        push("lowwater_pre", 0, S_WAT, 1, 0, 2, 0, 1);
        step(1, 0, 0, 0, 0, 0);
        push("lowwater_fault", 0, S_FLT, 0, 1, 0, 0, 1);
        step(1, 0, 0, 1, 0, 0);
        push("fault_tick_low", 0, S_FLT, 0, 1, 0, 0, 1);
        step(1, 1, 0, 1, 1, 1);
        push("fault_hold", 0, S_FLT, 0, 1, 0, 0, 1);
        step(1, 0, 0, 0, 1, 0);
        push("fault_hold2", 0, S_FLT, 0, 1, 0, 0, 1);
        step(1, 0, 1, 0, 0, 1);
        push("fault_exit", 0, S_IDLE, 0, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0, 0);

        push("prio_start", 0, S_WAT, 1, 0, 5, 1, 1);
        step(1, 0, 1, 0, 0, 0);
        push("prio_wl_ab_tk", 0, S_FLT, 0, 1, 0, 0, 1);
        step(1, 1, 0, 1, 0, 1);
        push("prio_exit", 0, S_IDLE, 0, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0, 0);

        push("idle_lowwater", 0, S_FLT, 0, 1, 0, 0, 1);
        step(1, 0, 1, 1, 1, 0);
        step(1, 1, 0, 0, 0, 0);

        push("pre_reset_start", 0, S_WAT, 1, 0, 5, 1, 1);
        step(1, 0, 0, 0, 1, 0);
        push("pre_reset_tick", 0, S_WAT, 1, 0, 4, 0, 1);
        step(1, 1, 0, 0, 0, 0);
        push("reset_mid_dose", 0, S_IDLE, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 1, 0);

        // Unit-length dose and rest on dut_b: one completed dose per three cycles.
        for (int i = 0; i < 256; i++) begin
            step(1, 0, 1, 0, 0, 0);
            push((i == 255) ? "wrap" : "b_dose", 1, S_REST, 0, 0, 1, 1, 8'(i + 1));
            step(1, 1, 0, 0, 0, 0);
            step(1, 1, 0, 0, 0, 0);
        end
        push("b_idle_after_wrap", 1, S_IDLE, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
